// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: instruction patterns and sequencer state.
package fetch_unit_pkg;

  localparam int unsigned OPCODE_W = 4;

  // {opcode, fcode} patterns decoded inside the fetch stage.
  localparam logic [4:0] cHALT = 5'b1111_1;
  localparam logic [4:0] cCALL = 5'b1110_0;
  localparam logic [4:0] cRET  = 5'b1101_0;

  localparam logic [8:0] kNOP_INST = 9'b0000_0_0000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction memory, decoder controls, datapath flags, start/done handshake.
interface fetch_unit_if #(
  parameter int unsigned PC_W   = 10,
  parameter int unsigned INST_W = 9
);
  logic              start;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_data;
  logic [3:0]        opcode;
  logic              fcode;
  logic [PC_W-1:0]   pc;
  logic              run;
  logic              CTRL_branch_rel_z;
  logic              CTRL_branch_rel_nz;
  logic              CTRL_branch_abs;
  logic              acc_zero;
  logic [5:0]        branch_off;
  logic [PC_W-1:0]   jump_target;
  logic              done;
  logic              fault;

  modport master (
    input  start, imem_data, CTRL_branch_rel_z, CTRL_branch_rel_nz, CTRL_branch_abs,
    input  acc_zero, branch_off, jump_target,
    output imem_addr, opcode, fcode, pc, run, done, fault
  );

  modport slave (
    output start, imem_data, CTRL_branch_rel_z, CTRL_branch_rel_nz, CTRL_branch_abs,
    output acc_zero, branch_off, jump_target,
    input  imem_addr, opcode, fcode, pc, run, done, fault
  );
endinterface

// File: rtl/fetch_unit_ret_addr_stack.sv
// Return-address stack; pointer counts 0..DEPTH, contents are not reset.
module ret_addr_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      sp_q;
  logic [AW-1:0]    top_idx;

  assign full    = (sp_q == (AW+1)'(DEPTH));
  assign empty   = (sp_q == '0);
  assign top_idx = sp_q[AW-1:0] - 1'b1;
  assign top     = mem_q[top_idx];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + 1'b1;
    end else if (pop && !empty) begin
      sp_q <= sp_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full && !reset && !clear) begin
      mem_q[sp_q[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch and sequencing stage: PC register, next-PC selection, call/return, start/done.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W      = 10,
  parameter int unsigned INST_W    = 9,
  parameter int unsigned RAS_DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  fetch_state_t    state_q;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc, rel_target, ras_top, off_ext;
  logic            fault_q;
  logic [4:0]      op_f;
  logic            is_run, is_halt, is_call, is_ret, launch;
  logic            ras_full, ras_empty, rel_taken;

  assign is_run  = (state_q == RUN);
  assign op_f    = {bus.imem_data[INST_W-1 -: OPCODE_W], bus.imem_data[INST_W-1-OPCODE_W]};
  assign is_halt = is_run && (op_f == cHALT);
  assign is_call = is_run && (op_f == cCALL);
  assign is_ret  = is_run && (op_f == cRET);
  assign launch  = !is_run && bus.start;

  assign pc_inc     = pc_q + 1'b1;
  assign off_ext    = {{(PC_W-6){bus.branch_off[5]}}, bus.branch_off};
  assign rel_target = pc_q + off_ext;
  assign rel_taken  = (bus.CTRL_branch_rel_z && bus.acc_zero) ||
                      (bus.CTRL_branch_rel_nz && !bus.acc_zero);

  ret_addr_stack #(
    .DEPTH(RAS_DEPTH),
    .WIDTH(PC_W)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .clear    (launch),
    .push     (is_call && !is_halt),
    .pop      (is_ret && !is_halt),
    .push_data(pc_inc),
    .top      (ras_top),
    .full     (ras_full),
    .empty    (ras_empty)
  );

  always_comb begin
    pc_d = pc_q;
    if (!is_run || is_halt) begin
      pc_d = pc_q;
    end else if (is_ret) begin
      pc_d = ras_empty ? pc_q : ras_top;
    end else if (is_call || bus.CTRL_branch_abs) begin
      pc_d = bus.jump_target;
    end else if (rel_taken) begin
      pc_d = rel_target;
    end else begin
      pc_d = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= RUN;
            pc_q    <= '0;
            fault_q <= 1'b0;
          end
        end
        RUN: begin
          pc_q <= pc_d;
          if (is_halt || (is_ret && ras_empty)) state_q <= DONE;
          if ((is_call && ras_full) || (is_ret && ras_empty)) fault_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.imem_addr = pc_q;
  assign bus.run       = is_run;
  assign bus.done      = (state_q == DONE);
  assign bus.fault     = fault_q;
  assign bus.opcode    = is_run ? op_f[4:1] : kNOP_INST[8:5];
  assign bus.fcode     = is_run ? op_f[0]   : kNOP_INST[4];

endmodule
